// File: rtl/cla_sub_seq.sv
// Sequential W-bit subtractor: one 4-bit carry-lookahead slice per clock,
// least-significant slice first, borrow carried between slices in a register.
// Produces diff = a - b - bin (mod 2^W) plus borrow-out, zero and signed overflow.
module cla_sub_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   bin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   bout,
   output logic                   zero,
   output logic                   ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_diff;
   logic             r_bout;
   logic             r_zero;
   logic             r_ovf;
   logic             w_accept;
   logic [CW+1:0]    w_idx;
   logic [4:0]       w_cla;
   logic [W-1:0]     w_diff_new;

   // 4-bit carry-lookahead adder: every internal carry is a flat sum of
   // generate/propagate products, so no carry depends on a previous carry.
   // Returns {carry_out, sum}.
   function automatic logic [4:0] cla4(input logic [3:0] x,
                                       input logic [3:0] y,
                                       input logic       cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

   // A new operation is taken whenever the unit is not mid-subtraction.
   assign w_accept = start && (r_state != S_BUSY);

   // Current slice: a + ~b + ~borrow, i.e. a - b - borrow in two's complement.
   assign w_idx = {r_cnt, 2'b00};
   assign w_cla = cla4(r_a[w_idx +: 4], ~r_b[w_idx +: 4], ~r_borrow);

   // Difference word as it will look after this edge's slice write.
   always_comb begin
      w_diff_new             = r_diff;
      w_diff_new[w_idx +: 4] = w_cla[3:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: BUSY lasts exactly NIBBLES edges, DONE exactly one.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == LAST) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_BUSY : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch: captured only on an accepted start, ignored during BUSY.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // Slice counter, inter-slice borrow, result word and final flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_borrow <= bin;
      end else if (r_state == S_BUSY) begin
         r_diff   <= w_diff_new;
         r_borrow <= ~w_cla[4];
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == LAST) begin
            r_bout <= ~w_cla[4];
            r_zero <= (w_diff_new == '0);
            r_ovf  <= (r_a[W-1] ^ r_b[W-1]) & (r_a[W-1] ^ w_diff_new[W-1]);
         end
      end
   end

   assign busy = (r_state == S_BUSY);
   assign done = (r_state == S_DONE);
   assign diff = r_diff;
   assign bout = r_bout;
   assign zero = r_zero;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Bench for cla_sub_seq: a scoreboard queue holds the expected result of each
// accepted operation; a monitor pops and compares whenever done is high.
module tb_cla_sub_seq;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         zero;
      logic         ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          bin = 1'b0;
   logic          busy;
   logic          done;
   logic [W-1:0]  diff;
   logic          bout;
   logic          zero;
   logic          ovf;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   cla_sub_seq #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .zero  (zero),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: 17-bit unsigned subtraction gives the borrow directly.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
      exp_t       e;
      logic [W:0] full;
      full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
      e.diff = full[W-1:0];
      e.bout = full[W];
      e.zero = (full[W-1:0] == '0);
      e.ovf  = (x[W-1] ^ y[W-1]) & (x[W-1] ^ full[W-1]);
      return e;
   endfunction

   // Present an operation to be sampled at the next rising edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
      start = 1'b1;
      a     = x;
      b     = y;
      bin   = bi;
      if (push) sb_q.push_back(model(x, y, bi));
   endtask

   // Step through the accepting edge, NIB-1 further busy edges and the done edge.
   task automatic run_op(input string tag);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy0"}, busy, 1);
      check({tag, "_done0"}, done, 0);
      for (int i = 1; i < NIB; i++) begin
         @(posedge clk); #1;
         check({tag, "_busy"}, busy, 1);
      end
      @(posedge clk); #1;
      check({tag, "_done"}, done, 1);
      check({tag, "_nbusy"}, busy, 0);
   endtask

   // Monitor: compare each completed result against the scoreboard.
   always @(negedge clk) begin
      if (done) begin
         if (busy) check("busy_and_done", 1, 0);
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", diff, e.diff);
            check("bout", bout, e.bout);
            check("zero", zero, e.zero);
            check("ovf",  ovf,  e.ovf);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for two edges.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      check("rst_zero", zero, 0);
      check("rst_ovf",  ovf,  0);
      rst_n = 1'b1;

      // Basic subtract, underflow, signed overflow.
      issue(16'h1234, 16'h0234, 1'b0, 1'b1); run_op("basic");
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      issue(16'h0000, 16'h0001, 1'b0, 1'b1); run_op("underflow");
      @(posedge clk); #1;
      issue(16'h8000, 16'h0001, 1'b0, 1'b1); run_op("sovf");
      @(posedge clk); #1;

      // Borrow-in producing zero, then back-to-back start in the DONE cycle.
      issue(16'h0005, 16'h0004, 1'b1, 1'b1); run_op("zero");
      issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); run_op("b2b");
      @(posedge clk); #1;
      check("b2b_done_fall", done, 0);

      // start re-asserted mid-operation with different operands is ignored.
      issue(16'hA5A5, 16'h1111, 1'b0, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      check("abuse_busy", busy, 1);
      issue(16'h0001, 16'hF00F, 1'b1, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abuse_done", done, 1);
      @(posedge clk); #1;

      // Reset sampled on the edge that would process slice 2.
      issue(16'h7654, 16'h0123, 1'b1, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_bout", bout, 0);
      check("abort_zero", zero, 0);
      check("abort_ovf",  ovf,  0);
      // Release reset and start on the very next edge.
      rst_n = 1'b1;
      issue(16'h0100, 16'h0200, 1'b0, 1'b1); run_op("post_rst");
      @(posedge clk); #1;

      // A few random operations.
      for (int i = 0; i < 6; i++) begin
         issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         run_op("rand");
      end
      @(posedge clk); #1;
      check("rand_idle", busy, 0);

      repeat (3) @(posedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
